uart_rx: RTL

//  Receive half of the AXI4-Stream UART. Oversamples the asynchronous rxd line at 8x
//  the bit rate and frames 8N1-style characters: one start bit, DATA_WIDTH data bits
//  (LSB first) and one stop bit. Presents each good character on an AXI4-Stream master

---
 rtl/uart_rx_pkg.sv | 23 ++
 rtl/uart_rx_sync_2ff.sv | 28 ++
 rtl/uart_rx.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: oversampling ratio, counter
// width, FSM state encoding and the bit-period helper.
package uart_rx_pkg;

    localparam int UART_OVERSAMPLE = 8;
    localparam int CNT_W           = 19;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

    // Clocks per bit for a given prescale; a prescale of zero behaves as one.
    function automatic logic [CNT_W-1:0] bit_period(input logic [15:0] prescale);
        logic [15:0] p;
        p = (prescale == 16'd0) ? 16'd1 : prescale;
        return {p, 3'b000};
    endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable
// reset value so an idle-high line does not look like a start bit at reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    // Two back-to-back flops to settle metastability before use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_reg <= RESET_VAL;
            sync_reg <= RESET_VAL;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8x oversampled rxd, start/data/stop framing, AXI4-Stream
// master output with overrun and framing error pulses.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    input  logic                  rxd,
    output logic                  busy,
    output logic                  overrun_error,
    output logic                  frame_error,
    input  logic [15:0]           prescale
);

    logic                  rxd_s;
    logic [CNT_W-1:0]      period;
    logic [DATA_WIDTH-1:0] shift_in;

    rx_state_t             state_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic [3:0]            bit_cnt_reg;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] tdata_reg;
    logic                  tvalid_reg;
    logic                  busy_reg;
    logic                  overrun_reg;
    logic                  frame_err_reg;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    // Prescale is looked at on every reload, so a change only affects later bits.
    assign period = bit_period(prescale);

    // Data arrives LSB first: the newest bit enters at the MSB and moves right.
    generate
        if (DATA_WIDTH == 1) begin : g_shift_one
            assign shift_in = rxd_s;
        end else begin : g_shift_wide
            assign shift_in = {rxd_s, shift_reg[DATA_WIDTH-1:1]};
        end
    endgenerate

    // Receive FSM with bit counter, shift register and registered stream outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            tdata_reg     <= '0;
            tvalid_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;

            // Accepted character; a load later in this block can re-raise tvalid.
            if (tvalid_reg && output_axis_tready) begin
                tvalid_reg <= 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (!rxd_s) begin
                        cnt_reg   <= (period >> 1) - 19'd1;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_START;
                    end
                end

                ST_START: begin
                    if (cnt_reg == '0) begin
                        if (rxd_s) begin
                            // Line went back high by mid start bit: treat as noise.
                            busy_reg  <= 1'b0;
                            state_reg <= ST_IDLE;
                        end else begin
                            cnt_reg     <= period - 19'd1;
                            bit_cnt_reg <= 4'(DATA_WIDTH);
                            state_reg   <= ST_DATA;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 19'd1;
                    end
                end

                ST_DATA: begin
                    if (cnt_reg == '0) begin
                        shift_reg   <= shift_in;
                        bit_cnt_reg <= bit_cnt_reg - 4'd1;
                        cnt_reg     <= period - 19'd1;
                        if (bit_cnt_reg == 4'd1) begin
                            state_reg <= ST_STOP;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 19'd1;
                    end
                end

                ST_STOP: begin
                    if (cnt_reg == '0) begin
                        if (rxd_s) begin
                            if (!tvalid_reg || output_axis_tready) begin
                                tdata_reg  <= shift_reg;
                                tvalid_reg <= 1'b1;
                            end else begin
                                // Previous character still unread: keep it, drop this one.
                                overrun_reg <= 1'b1;
                            end
                            // Leave at mid stop bit so the next start edge is caught early.
                            busy_reg  <= 1'b0;
                            state_reg <= ST_IDLE;
                        end else begin
                            frame_err_reg <= 1'b1;
                            state_reg     <= ST_BREAK;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 19'd1;
                    end
                end

                ST_BREAK: begin
                    // Hold off until the line recovers so a long break reports once.
                    if (rxd_s) begin
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end

                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign output_axis_tdata  = tdata_reg;
    assign output_axis_tvalid = tvalid_reg;
    assign busy               = busy_reg;
    assign overrun_error      = overrun_reg;
    assign frame_error        = frame_err_reg;

endmodule
